// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param_if
// Description : Signal bundle for the parametrised serial pattern detector.
//               master = stream source / pattern controller / count consumer,
//               slave  = detector.
//   x, x_valid  : serial bit and its qualifier
//   overlap     : 1 = overlapping matches, 0 = non-overlapping
//   pat_load    : load pat_in as the new pattern (clears history)
//   pat_in      : pattern to load, PAT_LEN bits
//   cnt_clr     : clears match_cnt and cnt_sat
//   z           : combinational match flag
//   match_cnt   : saturating match count
//   cnt_sat     : sticky saturation flag
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_detector_param_if #(
    parameter int PAT_LEN = 3,
    parameter int CNT_W   = 8
) ();
    logic               x;
    logic               x_valid;
    logic               overlap;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               cnt_clr;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output x, x_valid, overlap, pat_load, pat_in, cnt_clr,
        input  z, match_cnt, cnt_sat
    );

    modport slave (
        input  x, x_valid, overlap, pat_load, pat_in, cnt_clr,
        output z, match_cnt, cnt_sat
    );
endinterface
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Serial pattern detector with runtime-loadable pattern,
//               overlapping / non-overlapping matching, input qualification
//               and a saturating match counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_detector_param_if.slave (stream in, z / count out)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter int                 CNT_W   = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    seq_detector_param_if.slave    bus
);
    localparam int FILL_W = $clog2(PAT_LEN);

    localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_cnt_last  = c_cnt_max - CNT_W'(1);

    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic               sat_q,  sat_d;

    logic [PAT_LEN-1:0] shift_w;
    logic               z_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    always_comb begin
        // History with the current bit appended; its low PAT_LEN-1 bits are
        // also the next history, which covers PAT_LEN=2 without a special case.
        shift_w = {hist_q, bus.x};
        z_w     = bus.x_valid & ~bus.pat_load & (fill_q == c_fill_full)
                  & (shift_w == pat_q);

        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        sat_d  = sat_q;

        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.x_valid) begin
            hist_d = shift_w[PAT_LEN-2:0];
            // Non-overlapping: forget the bits just consumed by the match.
            if (z_w && !bus.overlap) begin
                fill_d = '0;
            end else if (fill_q != c_fill_full) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        if (bus.cnt_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (z_w && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == c_cnt_last) begin
                sat_d = 1'b1;
            end
        end
    end

    assign bus.z         = z_w;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Self-checking bench. Two detectors (CNT_W=8 and CNT_W=2)
//               share one stimulus stream; a queue-based model of the
//               received bit history predicts z and both counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;
    localparam int L = 3;

    logic         clk;
    logic         rst_n;
    logic         x_r, xv_r, ov_r, pl_r, clr_r;
    logic [L-1:0] pin_r;

    int n_cmp;
    int n_bad;

    // Model state: qualified bits since last reset/load/non-overlap match.
    bit       mq[$];
    bit [L-1:0] mpat;
    int       mc8, mc2;

    seq_detector_param_if #(.PAT_LEN(L), .CNT_W(8)) if8 ();
    seq_detector_param_if #(.PAT_LEN(L), .CNT_W(2)) if2 ();

    assign if8.x = x_r;   assign if2.x = x_r;
    assign if8.x_valid = xv_r;  assign if2.x_valid = xv_r;
    assign if8.overlap = ov_r;  assign if2.overlap = ov_r;
    assign if8.pat_load = pl_r; assign if2.pat_load = pl_r;
    assign if8.pat_in = pin_r;  assign if2.pat_in = pin_r;
    assign if8.cnt_clr = clr_r; assign if2.cnt_clr = clr_r;

    seq_detector_param #(.PAT_LEN(L), .PATTERN(3'b101), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8.slave)
    );
    seq_detector_param #(.PAT_LEN(L), .PATTERN(3'b101), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_z();
        bit [L-1:0] v;
        if (!xv_r || pl_r || mq.size() < L - 1) return 1'b0;
        v = '0;
        foreach (mq[i]) v = {v[L-2:0], mq[i]};
        v = {v[L-2:0], x_r};
        return v == mpat;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpat = 3'b101;
        mc8  = 0;
        mc2  = 0;
    endtask

    task automatic model_adv();
        bit zz;
        zz = model_z();
        if (clr_r) begin
            mc8 = 0;
            mc2 = 0;
        end else if (zz) begin
            if (mc8 < 255) mc8++;
            if (mc2 < 3)   mc2++;
        end
        if (pl_r) begin
            mpat = pin_r;
            mq.delete();
        end else if (xv_r) begin
            if (zz && !ov_r) mq.delete();
            else begin
                mq.push_back(x_r);
                if (mq.size() > L - 1) void'(mq.pop_front());
            end
        end
    endtask

    task automatic compare_model();
        bit ez;
        ez = model_z();
        chk("z8",   32'(if8.z), 32'(ez));
        chk("z2",   32'(if2.z), 32'(ez));
        chk("cnt8", 32'(if8.match_cnt), 32'(mc8));
        chk("sat8", 32'(if8.cnt_sat), 32'(mc8 == 255));
        chk("cnt2", 32'(if2.match_cnt), 32'(mc2));
        chk("sat2", 32'(if2.cnt_sat), 32'(mc2 == 3));
    endtask

    // One cycle: drive at posedge+1, check at negedge, advance model at posedge.
    // expz < 0 means no literal expectation for this cycle.
    task automatic cyc(input bit xb, input bit xv, input bit pl,
                       input logic [L-1:0] pin, input bit clr, input int expz);
        x_r = xb; xv_r = xv; pl_r = pl; pin_r = pin; clr_r = clr;
        @(negedge clk);
        compare_model();
        if (expz >= 0) chk("z_lit", 32'(if8.z), 32'(expz));
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic bits(input logic [15:0] s, input logic [15:0] ez, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(s[i], 1'b1, 1'b0, '0, 1'b0, int'(ez[i]));
    endtask

    task automatic rst_pulse();
        xv_r = 1'b0; pl_r = 1'b0; clr_r = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        x_r = 0; xv_r = 0; ov_r = 1; pl_r = 0; pin_r = '0; clr_r = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_z",   32'(if8.z), 32'd0);
        chk("rst_cnt", 32'(if8.match_cnt), 32'd0);
        chk("rst_sat", 32'(if8.cnt_sat), 32'd0);

        // 1: overlap, 1,0,1,0,1 -> z on bits 3 and 5
        ov_r = 1;
        bits(16'b10101, 16'b00101, 5);
        chk("t1_cnt", 32'(if8.match_cnt), 32'd2);

        // 2: non-overlap, 1,0,1,0,1,0,1 -> z on bits 3 and 7
        cyc(0, 0, 1, 3'b101, 1, 0);
        ov_r = 0;
        bits(16'b1010101, 16'b0010001, 7);
        chk("t2_cnt", 32'(if8.match_cnt), 32'd2);

        // 3: unqualified cycles ignored
        ov_r = 1;
        cyc(0, 0, 1, 3'b101, 1, 0);
        cyc(1, 1, 0, '0, 0, 0);
        cyc(0, 0, 0, '0, 0, 0);
        cyc(0, 1, 0, '0, 0, 0);
        cyc(1, 0, 0, '0, 0, 0);
        cyc(1, 1, 0, '0, 0, 1);
        chk("t3_cnt", 32'(if8.match_cnt), 32'd1);

        // 4: load 110 while a valid 1 is presented
        cyc(1, 1, 1, 3'b110, 0, 0);
        bits(16'b110110, 16'b001001, 6);

        // 5: saturation of the 2-bit counter and clear beside a match
        cyc(0, 0, 1, 3'b101, 1, 0);
        bits(16'b1010101, 16'b0010101, 7);
        chk("t5_cnt2_3", 32'(if2.match_cnt), 32'd3);
        chk("t5_sat2",   32'(if2.cnt_sat), 32'd1);
        bits(16'b01, 16'b01, 2);
        chk("t5_cnt2_hold", 32'(if2.match_cnt), 32'd3);
        chk("t5_cnt8_4",    32'(if8.match_cnt), 32'd4);
        cyc(0, 1, 0, '0, 0, 0);
        cyc(1, 1, 0, '0, 1, 1);
        chk("t5_clr_cnt", 32'(if2.match_cnt), 32'd0);
        chk("t5_clr_sat", 32'(if2.cnt_sat), 32'd0);
        chk("t5_clr_cnt8", 32'(if8.match_cnt), 32'd0);

        // 6: reset mid-sequence discards the partial match
        cyc(0, 0, 1, 3'b101, 1, 0);
        bits(16'b10, 16'b00, 2);
        rst_pulse();
        bits(16'b101, 16'b001, 3);

        // Randomized stream against the model
        for (int n = 0; n < 3000; n++) begin
            ov_r = ($urandom_range(0, 15) != 0) ? ov_r : ~ov_r;
            cyc(1'($urandom_range(0, 1)),
                $urandom_range(0, 9) < 8,
                $urandom_range(0, 39) == 0,
                3'($urandom_range(0, 7)),
                $urandom_range(0, 59) == 0,
                -1);
            if ($urandom_range(0, 299) == 0) rst_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector that extends the fixed 3-bit "101" detector to any pattern length, with a runtime-loadable pattern, selectable overlapping or non-overlapping matching, input qualification and a saturating match counter. It sits on a 1-bit serial stream inside a datapath and flags, in the same cycle, each qualified bit that completes the pattern. Downstream logic consumes either the single-cycle Mealy flag or the running count.

## Interface
- PAT_LEN, 3: pattern length in bits; legal range 2..32.
- PATTERN, 3'b101: reset and default pattern, PAT_LEN bits wide; MSB is compared against the oldest bit.
- CNT_W, 8: width of the match counter; legal range 1..32.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- x_valid  in  1  qualifies x; unqualified cycles are ignored entirely.
- overlap  in  1  1 = overlapping match, 0 = non-overlapping; sampled on every qualified bit.
- pat_load  in  1  loads pat_in into the pattern register.
- pat_in  in  PAT_LEN  new pattern.
- cnt_clr  in  1  synchronous clear of match_cnt and cnt_sat.
- z  out  1  Mealy match flag, combinational.
- match_cnt  out  CNT_W  number of matches since reset or clear, saturating.
- cnt_sat  out  1  sticky; set when match_cnt reaches all-ones.

## Operation
- Registers:
  - pat, PAT_LEN bits; resets to PATTERN.
  - hist, PAT_LEN-1 bits: the last qualified bits, newest in the LSB; resets to 0.
  - fill, a count of valid history bits that saturates at PAT_LEN-1; resets to 0.
  - match_cnt; resets to 0.
  - cnt_sat; resets to 0.
- Bit order: the first bit received in a sequence is compared to pat[PAT_LEN-1]. The current x is compared to pat[0].
- Match condition: z = x_valid & !pat_load & (fill == PAT_LEN-1) & ({hist, x} == pat).
- Qualified bit (x_valid=1, pat_load=0):
  - Always shift: hist <= {hist[PAT_LEN-3:0], x}. For PAT_LEN=2, hist <= x.
  - If z=1 and overlap=0: fill <= 0. The matched bits are not reused.
  - Otherwise: fill <= min(fill+1, PAT_LEN-1).
- Unqualified bit (x_valid=0): hist, fill and the counter all hold; z=0.
- pat_load=1:
  - pat <= pat_in; hist <= 0; fill <= 0.
  - x is ignored that cycle and z is forced to 0.
  - pat_load has priority over x_valid.
- Counter:
  - On z=1, match_cnt increments unless it is already all-ones. It never wraps.
  - cnt_sat <= 1 on the same edge that match_cnt becomes all-ones, and stays set until cleared.
- cnt_clr=1: match_cnt <= 0 and cnt_sat <= 0. cnt_clr has priority over a simultaneous increment. z still asserts that cycle, and hist/fill still update normally.
- Equivalent FSM view: states 0..PAT_LEN-1 (matched-prefix depth).
  - In overlap mode the successor state after a match equals the longest proper suffix of the pattern that is also a prefix.
  - The shift-register implementation above is the required behaviour.
  - Any implementation must be cycle-identical to it.

## Timing
- z is combinational from x, x_valid, pat_load and the registers, with zero latency. It is high only during the cycle in which the completing bit is presented.
- match_cnt and cnt_sat update on the rising edge that ends the matching cycle, so they are visible 1 cycle after z.
- A loaded pattern is effective from the cycle after pat_load. The first possible match is the PAT_LEN-th qualified bit after the load.
- Reset:
  - Asynchronous assert: all registers reach their reset values immediately.
  - While rst=0, z=0 because fill=0.
  - Reset mid-sequence discards partial matches. Detection restarts from an empty history on the first qualified bit after deassertion.
- No match is possible until PAT_LEN qualified bits have been received after a reset, load or non-overlapping match.

## Test plan
1. Overlap, defaults (PAT_LEN=3, PATTERN=101), overlap=1, stream 1,0,1,0,1 all valid -> z=1 on bits 3 and 5 only; match_cnt=2 one cycle after bit 5.
2. Non-overlap, same stream with overlap=0 -> z=1 on bit 3 only; bits 4-5 leave fill=2; match_cnt=1. A following bit 1 -> z=0. The sequence 0,1 would then be required: stream 1,0,1,0,1,0,1 gives z on bits 3 and 7.
3. Gaps: bits 1,(x=0 with x_valid=0),0,(x=1 with x_valid=0),1 -> the ignored cycles have no effect; z=1 on the final qualified 1; match_cnt=1.
4. Pattern load: pat_load with pat_in=3'b110 while x_valid=1 and x=1 -> no z that cycle. Then stream 1,1,0,1,1,0 -> z=1 on bits 3 and 6.
5. Saturation and clear with CNT_W=2, overlap=1, stream 1,0,1,0,1,0,1,0,1:
   - Expected: 4 matches; match_cnt sticks at 3 with cnt_sat=1 after the 3rd match.
   - Then assert cnt_clr together with a 5th match -> z=1, match_cnt=0, cnt_sat=0.
6. Reset mid-operation: stream 1,0, then pulse rst low between edges, then 1 -> z=0. Then 0,1 -> z=1 on the last bit.
